// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial
//
// Digit-serial packed-BCD adder/subtractor. One decimal digit is processed
// per clock, least-significant digit first. Each digit is added in binary
// and corrected by +6 when the binary sum exceeds 9. Subtraction adds the
// nine's complement of B, with the incoming carry set to the inverse of
// the borrow-in. That gives ten's-complement subtraction.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand set present on a, b, sub, cin
//   in_ready   high while idle; the operand set is accepted on in_valid & in_ready
//   a, b       packed BCD operands, digit i at [4i+3:4i]
//   sub        0 = A+B+cin, 1 = A-B-cin
//   cin        carry-in (add) / borrow-in (subtract)
//   out_valid  result present; sum/cout/invalid are held stable until consumed
//   out_ready  consumer accepts the result
//   sum        packed BCD result
//   cout       add: decimal carry out; subtract: 1 = no borrow
//   invalid    some digit of a or b was greater than 9

module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry;
  logic [CW-1:0] cnt;

  logic [W-1:0]  b_prep;
  logic          in_bad;
  logic [4:0]    raw;
  logic [3:0]    digit;
  logic          digit_carry;
  logic [W-1:0]  sum_shift;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand preparation at acceptance time. The validity check looks at the
  // raw b digits, so it is unaffected by the complement. An out-of-range b
  // digit simply wraps modulo 16 in the complement.
  always_comb begin
    b_prep = '0;
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      b_prep[4*i +: 4] = sub ? 4'(4'd9 - b[4*i +: 4]) : b[4*i +: 4];
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9))
        in_bad = 1'b1;
    end
  end

  // Single-digit BCD add. The operand registers shift right every RUN cycle,
  // so the current digit is always in the low nibble. The maximum raw value
  // is 9+9+1 = 19, which fits in 5 bits. The new digit enters sum at the MS
  // end, so after DIGITS shifts digit 0 has reached sum[3:0].
  always_comb begin
    raw = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'b0000, carry};
    if (raw > 5'd9) begin
      digit       = 4'(raw[3:0] + 4'd6);
      digit_carry = 1'b1;
    end else begin
      digit       = raw[3:0];
      digit_carry = 1'b0;
    end
    sum_shift           = sum >> 4;
    sum_shift[W-1 -: 4] = digit;
  end

  // Control and datapath state. Reset aborts any operation in progress.
  // DONE returns only to IDLE, so a new operand cannot be captured in the
  // same cycle that a result is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b_prep;
            carry   <= sub ? ~cin : cin;
            invalid <= in_bad;
            sum     <= '0;
            cout    <= 1'b0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_shift;
          a_reg <= a_reg >> 4;
          b_reg <= b_reg >> 4;
          carry <= digit_carry;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout  <= digit_carry;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// tb_bcd_addsub_serial
//
// Directed testbench for bcd_addsub_serial. It builds one DIGITS=4 instance
// and one DIGITS=1 instance. Expected values are hand-computed decimal
// results.

module tb_bcd_addsub_serial;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        invalid;

  logic        in_valid1;
  logic        in_ready1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        out_valid1;
  logic        out_ready1;
  logic [3:0]  sum1;
  logic        cout1;
  logic        invalid1;

  int total;
  int bad;

  bcd_addsub_serial #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .invalid(invalid)
  );

  bcd_addsub_serial #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(1'b0), .cin(1'b0),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .invalid(invalid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand set for a single edge. The caller makes sure the
  // DUT is idle first.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic s, input logic c);
    a = av; b = bv; sub = s; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid appears. Returns -1 if
  // the bound expires.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Runs one full operation and checks its result, latency and invalid flag.
  task automatic run_check(input string name, input logic [15:0] av,
                           input logic [15:0] bv, input logic s,
                           input logic c, input logic [15:0] exp_sum,
                           input logic exp_cout, input logic exp_inv);
    int lat;
    start_op(av, bv, s, c);
    wait_result(lat);
    total++;
    if (lat !== 4) begin
      bad++; $display("[TB] FAIL %s latency got=%0d want=4", name, lat);
    end
    total++;
    if (sum !== exp_sum) begin
      bad++; $display("[TB] FAIL %s sum got=%h want=%h", name, sum, exp_sum);
    end
    total++;
    if (cout !== exp_cout) begin
      bad++; $display("[TB] FAIL %s cout got=%b want=%b", name, cout, exp_cout);
    end
    total++;
    if (invalid !== exp_inv) begin
      bad++; $display("[TB] FAIL %s invalid got=%b want=%b", name, invalid, exp_inv);
    end
    consume();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL %s in_ready_after got=%b want=1", name, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset in_ready got=%b want=1", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset out_valid got=%b want=0", out_valid);
    end
    total++;
    if ({sum, cout, invalid} !== 18'd0) begin
      bad++; $display("[TB] FAIL reset outputs got=%h/%b/%b want=0", sum, cout, invalid);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    run_check("add", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
  endtask

  task automatic test_carry;
    run_check("ripple1", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_check("ripple2", 16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0);
  endtask

  task automatic test_subtract;
    run_check("sub1", 16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0);
    run_check("sub2", 16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0, 1'b0);
    run_check("sub3", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0);
  endtask

  task automatic test_invalid;
    int lat;
    start_op(16'h00A0, 16'h0000, 1'b0, 1'b0);
    wait_result(lat);
    total++;
    if (lat !== 4) begin
      bad++; $display("[TB] FAIL inv latency got=%0d want=4", lat);
    end
    total++;
    if (invalid !== 1'b1) begin
      bad++; $display("[TB] FAIL inv flag got=%b want=1", invalid);
    end
    consume();
    run_check("after_inv", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(16'h2500, 16'h2500, 1'b0, 1'b0);
    wait_result(lat);
    total++;
    if (lat !== 4) begin
      bad++; $display("[TB] FAIL bp latency got=%0d want=4", lat);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready} !== 2'b10) begin
        bad++; $display("[TB] FAIL bp hs[%0d] valid/ready got=%b%b want=10", i, out_valid, in_ready);
      end
      total++;
      if ({sum, cout} !== {16'h5000, 1'b0}) begin
        bad++; $display("[TB] FAIL bp hold[%0d] got=%h/%b want=5000/0", i, sum, cout);
      end
    end
    in_valid = 1'b0;
    consume();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("[TB] FAIL bp release valid/ready got=%b%b want=01", out_valid, in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
        bad++; $display("[TB] FAIL bp idle[%0d] valid/ready got=%b%b want=01", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_abort;
    logic seen;
    seen = 1'b0;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, sum, cout, invalid} !== 19'd0) begin
      bad++; $display("[TB] FAIL abort outputs got=%b/%h/%b/%b want=0", out_valid, sum, cout, invalid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("[TB] FAIL abort spurious_valid got=%b want=0", seen);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL abort in_ready got=%b want=1", in_ready);
    end
    run_check("post_abort", 16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
  endtask

  task automatic test_min_width;
    int lat;
    total++;
    if (in_ready1 !== 1'b1) begin
      bad++; $display("[TB] FAIL d1 in_ready got=%b want=1", in_ready1);
    end
    a1 = 4'd7; b1 = 4'd5; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid1) lat = -1;
    total++;
    if (lat !== 1) begin
      bad++; $display("[TB] FAIL d1 latency got=%0d want=1", lat);
    end
    total++;
    if ({sum1, cout1, invalid1} !== {4'd2, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL d1 result got=%h/%b/%b want=2/1/0", sum1, cout1, invalid1);
    end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    total++;
    if ({out_valid1, in_ready1} !== 2'b01) begin
      bad++; $display("[TB] FAIL d1 release valid/ready got=%b%b want=01", out_valid1, in_ready1);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
    test_reset();
    test_add();
    test_carry();
    test_subtract();
    test_invalid();
    test_backpressure();
    test_reset_abort();
    test_min_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_addsub_serial.md
# bcd_addsub_serial

Parametrised, digit-serial BCD adder/subtractor for multi-digit packed-BCD operands. It processes one decimal digit per clock, least-significant first, using the same binary-add-then-correct-by-6 rule as the single-digit combinational BCD adder. Subtraction uses nine's-complement of B. Operands enter through a valid/ready handshake and results leave through one, so the block sits between a BCD operand source and a BCD display or accumulator path.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits per operand; legal range ≥1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set present on a, b, sub, cin.
- in_ready  output  1  high exactly when the FSM is in IDLE.
- a  input  4*DIGITS  packed BCD operand A; digit i is a[4i+3:4i].
- b  input  4*DIGITS  packed BCD operand B.
- sub  input  1  0 = add (A+B+cin); 1 = subtract (A−B−cin).
- cin  input  1  carry-in for add, borrow-in for subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  4*DIGITS  packed BCD result.
- cout  output  1  add: decimal carry out. Subtract: 1 = no borrow (A ≥ B+cin); 0 = borrow, and sum is the ten's complement.
- invalid  output  1  at least one input digit of a or b was > 9.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid & in_ready: latch a; latch b' = (sub ? 9−b_i per digit : b_i); set carry = (sub ? ~cin : cin).
  - Set invalid = OR over all digits of (a_i > 9 | b_i > 9), evaluated on raw b before complement.
  - Clear sum and cout; reset digit counter to 0; go to RUN.
- **RUN (one digit per cycle, counter i = 0..DIGITS−1):**
  - s = a_i + b'_i + carry (5-bit unsigned).
  - If s > 9: digit = (s + 6)[3:0] and carry = 1. Otherwise digit = s[3:0] and carry = 0.
  - Digit is shifted into sum from the MS end, so after DIGITS shifts digit 0 sits at sum[3:0].
  - On i = DIGITS−1: cout ← final carry; go to DONE.
- Nine's complement of an invalid b digit is computed as 4-bit (9 − b_i) mod 16. Results for invalid inputs are deterministic per these rules but numerically meaningless; only the invalid flag is specified for checking.
- **DONE:**
  - out_valid = 1; sum, cout and invalid held stable.
  - On out_valid & out_ready: go to IDLE.
- in_valid is ignored in RUN and DONE (in_ready = 0). No operand is captured in the same cycle a result is consumed.
- Counter width: $clog2(DIGITS), minimum 1 bit. DIGITS = 1 must work; RUN then lasts one cycle.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, sum 0, cout 0, invalid 0, internal carry and counter 0.
- Reset asserted in any state aborts the operation immediately. No out_valid is produced for the aborted operand.
- Latency: acceptance edge at T0; out_valid rises after edge T0+DIGITS (RUN occupies DIGITS cycles).
- in_ready is high again in the cycle after the out_valid & out_ready edge.
- Minimum initiation interval: DIGITS + 2 cycles.
- sum, cout and invalid are checked only while out_valid = 1. They must not change while out_valid = 1 and out_ready = 0.

## Test plan
- **Add, DIGITS=4:** a=0x1234, b=0x5678, sub=0, cin=0 → sum=0x6912, cout=0, invalid=0. out_valid rises exactly 4 cycles after the acceptance edge.
- **Carry ripple:**
  - 0x9999 + 0x0001, cin=0 → sum=0x0000, cout=1.
  - 0x9999 + 0x9999, cin=1 → sum=0x9999, cout=1.
- **Subtract:**
  - 0x5000 − 0x1234, cin=0 → sum=0x3766, cout=1.
  - 0x1234 − 0x5000 → sum=0x6234, cout=0.
  - 0x0000 − 0x0000, cin=1 → sum=0x9999, cout=0.
- **Invalid digit:** a=0x00A0, b=0x0000 → invalid=1. A following valid operation (0x0001+0x0001 → 0x0002) returns invalid=0.
- **Backpressure:**
  - Hold out_ready=0 for 5 cycles after out_valid: sum, cout and out_valid stay stable, in_ready stays 0, and an in_valid pulse is ignored.
  - Then raise out_ready: one handshake occurs, and in_ready goes high the next cycle.
- **Reset and minimum width:**
  - Assert rst after 2 RUN cycles: out_valid never asserts, outputs read 0, in_ready=1 after release, and the next operation 0x0042+0x0058 gives 0x0100.
  - Separate DIGITS=1 build: 7+5 → sum=2, cout=1, latency 1 cycle.
